// File: rtl/rle_decoder_if.sv
// Stream interface for the run-length decoder: an input stream of
// (value, count) pairs and an output stream of expanded samples.
interface rle_decoder_if #(
    parameter int DATA_W = 13,
    parameter int CNT_W  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_value;
    logic        [CNT_W-1:0]  in_count;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;

    // Producer of pairs / consumer of samples.
    modport master (
        output in_valid, in_value, in_count, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // The decoder itself.
    modport slave (
        input  in_valid, in_value, in_count, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rle_decoder.sv
// Run-length decoder: buffers (value, count) pairs in a small FIFO and
// expands each pair into 'count' copies of 'value', one sample per cycle.
// The next pair is popped on the same edge that retires the last sample
// of the current run, so back-to-back runs stream without bubbles.
module rle_decoder #(
    parameter int DATA_W     = 13,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rle_decoder_if.slave      bus,
    output logic              busy,
    output logic              err_zero_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {
        S_IDLE,
        S_EXPAND
    } state_e;

    // Pair FIFO storage and bookkeeping.
    logic signed [DATA_W-1:0] r_fifo_value [FIFO_DEPTH];
    logic        [CNT_W-1:0]  r_fifo_count [FIFO_DEPTH];
    logic        [PTR_W-1:0]  r_wr_ptr;
    logic        [PTR_W-1:0]  r_rd_ptr;
    logic        [OCC_W-1:0]  r_occ;

    // Expander state.
    state_e                   r_state;
    state_e                   w_state_next;
    logic signed [DATA_W-1:0] r_value;
    logic        [CNT_W-1:0]  r_remaining;
    logic                     r_err_zero_cnt;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_load;
    logic                     w_fire;
    logic                     w_run_end;
    logic                     w_zero_pop;
    logic signed [DATA_W-1:0] w_head_value;
    logic        [CNT_W-1:0]  w_head_count;

    assign w_full       = (r_occ == OCC_W'(FIFO_DEPTH));
    assign w_empty      = (r_occ == '0);
    // Ready depends on occupancy alone: a full FIFO never accepts, even
    // if a pop happens on the same edge.
    assign w_push       = bus.in_valid & ~w_full;
    assign w_head_value = r_fifo_value[r_rd_ptr];
    assign w_head_count = r_fifo_count[r_rd_ptr];
    assign w_fire       = (r_state == S_EXPAND) & bus.out_ready;
    assign w_run_end    = w_fire & (r_remaining == CNT_W'(1));
    assign w_zero_pop   = w_pop & (w_head_count == '0);

    // Write incoming pairs into the FIFO storage.
    // NOTE: the storage array has no reset; stale entries are never read
    // because the pointers and occupancy are reset, and leaving it out
    // keeps the array mappable to plain RAM/flops without reset muxes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_value[r_wr_ptr] <= bus.in_value;
            r_fifo_count[r_wr_ptr] <= bus.in_count;
        end
    end

    // Advance FIFO pointers and occupancy on push/pop.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Expander state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic: decide when to pop the FIFO and load a new run.
    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_count != '0) begin
                        w_load       = 1'b1;
                        w_state_next = S_EXPAND;
                    end
                end
            end
            S_EXPAND: begin
                if (w_run_end) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_head_count != '0) w_load       = 1'b1;
                        else                    w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Run datapath: load a new run, count it down, flag zero-count pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value        <= '0;
            r_remaining    <= '0;
            r_err_zero_cnt <= 1'b0;
        end else begin
            if (w_load) begin
                r_value     <= w_head_value;
                r_remaining <= w_head_count;
            end else if (w_run_end) begin
                r_remaining <= '0;
            end else if (w_fire && (r_remaining > CNT_W'(1))) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
            if (w_zero_pop) r_err_zero_cnt <= 1'b1;
        end
    end

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = (r_state == S_EXPAND);
    assign bus.out_data  = r_value;
    assign bus.out_last  = (r_state == S_EXPAND) & (r_remaining == CNT_W'(1));
    assign busy          = (r_state == S_EXPAND) | ~w_empty;
    assign err_zero_cnt  = r_err_zero_cnt;

endmodule

// File: tb/tb_rle_decoder.sv
// Self-checking bench for rle_decoder: a table of single-pair runs,
// hand-written multi-cycle corner cases, and randomized pair streams
// with random back-pressure checked against a queue-based model.
module tb_rle_decoder;

    localparam int DW = 13;
    localparam int CW = 8;

    typedef logic signed [DW-1:0] data_t;
    typedef struct { data_t data; logic last; int cyc; } sample_t;
    typedef struct { data_t value; logic [CW-1:0] count; } pair_t;
    typedef struct {
        data_t          value;
        logic [CW-1:0]  count;
        int             exp_n;
        data_t          exp_data;
        logic           exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    logic busy;
    logic err_zero_cnt;

    rle_decoder_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    rle_decoder #(.DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .busy         (busy),
        .err_zero_cnt (err_zero_cnt)
    );

    int      n_vec = 0;
    int      n_err = 0;
    int      cyc   = 0;
    logic    mon_chk = 1'b0;
    sample_t mon_q[$];
    sample_t exp_q[$];
    pair_t   pq[$];
    vec_t    vecs[7];
    logic    done;
    logic    exp_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: records every handshake and, when armed, compares
    // each visible sample (including stalled cycles) with the model.
    initial begin
        int k;
        forever begin
            @(negedge clk);
            if (rst_n && mon_chk && bus.out_valid) begin
                k = mon_q.size();
                if (k < exp_q.size()) begin
                    check("out_data", bus.out_data, exp_q[k].data);
                    check("out_last", bus.out_last, exp_q[k].last);
                end else begin
                    check("extra_sample", bus.out_valid, 1'b0);
                end
            end
            if (rst_n && bus.out_valid && bus.out_ready)
                mon_q.push_back('{data: bus.out_data, last: bus.out_last, cyc: cyc});
        end
    end

    // Reference model: every non-zero pair becomes 'count' samples of
    // 'value' with last on the final one; zero-count pairs vanish.
    task automatic arm();
        exp_q.delete();
        mon_q.delete();
        exp_err = 1'b0;
        foreach (pq[i]) begin
            if (pq[i].count == 0) exp_err = 1'b1;
            for (int j = 0; j < int'(pq[i].count); j++)
                exp_q.push_back('{data: pq[i].value, last: (j == int'(pq[i].count) - 1), cyc: 0});
        end
        mon_chk = 1'b1;
    endtask

    task automatic add(input data_t v, input logic [CW-1:0] c);
        pq.push_back('{value: v, count: c});
    endtask

    task automatic do_reset();
        mon_chk      = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic push_pair(input data_t v, input logic [CW-1:0] c);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_count = c;
        @(negedge clk);
        while (!bus.in_ready && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (!bus.in_ready) check("push_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic push_all();
        foreach (pq[i]) push_pair(pq[i].value, pq[i].count);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        @(negedge clk);
        while ((busy || bus.out_valid) && t < budget) begin
            t++;
            @(negedge clk);
        end
        check("idle_timeout", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_done(input string name);
        check(name, mon_q.size(), exp_q.size());
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.in_count  = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{value: 7,     count: 3,   exp_n: 3,   exp_data: 7,     exp_err: 1'b0};
        vecs[1] = '{value: -5,    count: 1,   exp_n: 1,   exp_data: -5,    exp_err: 1'b0};
        vecs[2] = '{value: 4095,  count: 1,   exp_n: 1,   exp_data: 4095,  exp_err: 1'b0};
        vecs[3] = '{value: 1,     count: 255, exp_n: 255, exp_data: 1,     exp_err: 1'b0};
        vecs[4] = '{value: 3,     count: 0,   exp_n: 0,   exp_data: 0,     exp_err: 1'b1};
        vecs[5] = '{value: -4096, count: 2,   exp_n: 2,   exp_data: -4096, exp_err: 1'b0};
        vecs[6] = '{value: -1,    count: 128, exp_n: 128, exp_data: -1,    exp_err: 1'b0};

        // Asynchronous reset values while rst_n is held low.
        #12;
        check("rst_async_valid", bus.out_valid, 1'b0);
        check("rst_async_busy", busy, 1'b0);

        // Reset state after release.
        do_reset();
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_zero_cnt, 1'b0);

        // Latency and cycle-exact run of (7,3).
        pq.delete(); add(7, 3); arm();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_value  = 7;
        bus.in_count  = 3;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_n_valid", bus.out_valid, 1'b0);
        check("lat_n_busy", busy, 1'b1);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("lat_valid", bus.out_valid, 1'b1);
            check("lat_data", bus.out_data, 7);
            check("lat_last", bus.out_last, (s == 2));
        end
        @(negedge clk);
        check("lat_end_valid", bus.out_valid, 1'b0);
        check("lat_end_busy", busy, 1'b0);
        check("lat_end_data_hold", bus.out_data, 7);
        check_done("lat_count");
        @(posedge clk);
        #1;

        // Table of single-pair runs.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            mon_q.delete();
            bus.out_ready = 1'b1;
            push_pair(vecs[v].value, vecs[v].count);
            wait_idle(600);
            check("tbl_count", mon_q.size(), vecs[v].exp_n);
            foreach (mon_q[k]) begin
                check("tbl_data", mon_q[k].data, vecs[v].exp_data);
                check("tbl_last", mon_q[k].last, (k == vecs[v].exp_n - 1));
            end
            check("tbl_err", err_zero_cnt, vecs[v].exp_err);
        end

        // Back-to-back runs stream with no gaps.
        do_reset();
        pq.delete(); add(-5, 1); add(12, 2); add(4095, 1); arm();
        bus.out_ready = 1'b1;
        push_all();
        wait_idle(50);
        check_done("b2b_count");
        for (int k = 1; k < 4 && k < mon_q.size(); k++)
            check("b2b_gap", mon_q[k].cyc - mon_q[k-1].cyc, 1);

        // Stall: one pair sits in the expander, four fill the FIFO, the
        // sixth must wait until the stream drains.
        do_reset();
        bus.out_ready = 1'b0;
        pq.delete();
        add(10, 2); add(11, 1); add(12, 3); add(13, 1); add(14, 2); add(15, 1);
        arm();
        for (int i = 0; i < 5; i++) push_pair(pq[i].value, pq[i].count);
        @(negedge clk);
        check("stall_full", bus.in_ready, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_value = 15;
        bus.in_count = 1;
        repeat (4) begin
            @(negedge clk);
            check("stall_sixth_waits", bus.in_ready, 1'b0);
            check("stall_valid", bus.out_valid, 1'b1);
        end
        check("stall_no_output", mon_q.size(), 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        push_pair(15, 1);
        wait_idle(100);
        check_done("stall_count");

        // Zero-count pair is dropped and flagged; flag is sticky.
        do_reset();
        pq.delete(); add(3, 0); add(9, 2); arm();
        bus.out_ready = 1'b1;
        push_all();
        wait_idle(50);
        check("zero_err", err_zero_cnt, 1'b1);
        check_done("zero_count");
        pq.delete(); add(2, 1); arm();
        push_all();
        wait_idle(50);
        check("zero_err_sticky", err_zero_cnt, 1'b1);
        check_done("zero_after_count");

        // Reset during the 2nd sample of (4,10) with two pairs queued.
        do_reset();
        pq.delete(); add(4, 10); add(5, 2); add(6, 3); arm();
        bus.out_ready = 1'b1;
        push_all();
        check("mid_one_sample", mon_q.size(), 1);
        check("mid_valid", bus.out_valid, 1'b1);
        check("mid_data", bus.out_data, 4);
        rst_n = 1'b0;
        #1;
        mon_chk = 1'b0;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_data", bus.out_data, 0);
        check("mid_rst_last", bus.out_last, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err", err_zero_cnt, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_q.delete();
        @(posedge clk);
        #1;
        check("mid_rel_in_ready", bus.in_ready, 1'b1);
        repeat (8) @(negedge clk);
        check("mid_no_residual", mon_q.size(), 0);
        check("mid_idle_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        pq.delete(); add(8, 1); arm();
        push_all();
        wait_idle(20);
        check_done("mid_new_count");

        // Randomized pair streams with random back-pressure.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            pq.delete();
            for (int i = 0; i < 30; i++) begin
                int sel;
                logic [CW-1:0] c;
                sel = $urandom_range(0, 12);
                if (sel == 0)       c = '0;
                else if (sel == 12) c = CW'($urandom_range(7, 40));
                else                c = CW'($urandom_range(1, 6));
                add(data_t'($urandom), c);
            end
            arm();
            done = 1'b0;
            fork
                begin
                    foreach (pq[i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        push_pair(pq[i].value, pq[i].count);
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1 bus.out_ready = ($urandom_range(0, 2) != 0);
                    end
                    bus.out_ready = 1'b1;
                end
            join
            wait_idle(3000);
            check_done("rand_count");
            check("rand_err", err_zero_cnt, exp_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
